// File: rtl/plic_gw.sv
// plic_gw: platform-level interrupt controller with level/edge gateways,
// claim/complete in-service locking and a single-beat AXI register slave.
//
//   state   | meaning
//   WR_IDLE | AW and W both ready, nothing held
//   WR_ADDR | AW held, waiting for W
//   WR_DATA | W held, waiting for AW
//   WR_EXEC | both held, register update this cycle
//   WR_RESP | B response presented, waiting for bready
module plic_gw #(
    parameter int          NDEV   = 32,
    parameter int          NCTX   = 2,
    parameter int          PRIO_W = 3,
    parameter logic [63:0] BASE   = 64'hc000000,
    parameter int          ADDR_W = 28
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NDEV-1:0]   int_vect,
    output logic [NCTX-1:0]   irq,
    input  logic [7:0]        s_axi_awid,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [31:0]       s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [7:0]        s_axi_bid,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [7:0]        s_axi_arid,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [7:0]        s_axi_rid,
    output logic [31:0]       s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rlast,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready
);
    localparam int ID_W   = $clog2(NDEV);
    localparam int CTX_W  = (NCTX > 1) ? $clog2(NCTX) : 1;
    localparam int NWORDS = (NDEV + 31) / 32;
    localparam int WORD_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int NPAD   = NWORDS * 32;
    localparam logic [ADDR_W-1:0] BASE_A = BASE[ADDR_W-1:0];
    localparam logic [NDEV-1:0]   SRC_MASK = {{(NDEV-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {
        RK_NONE, RK_PRIO, RK_PEND, RK_MODE, RK_EN, RK_THR, RK_CLAIM
    } reg_kind_e;

    typedef struct packed {
        reg_kind_e        kind;
        logic             err;
        logic [ID_W-1:0]  idx;
        logic [CTX_W-1:0] ctx;
    } reg_dec_t;

    typedef enum logic [2:0] {
        WR_IDLE, WR_ADDR, WR_DATA, WR_EXEC, WR_RESP
    } wr_state_e;

    // Range checks are done on the full offset so that out-of-window
    // contexts or sources can never alias onto a valid index.
    function automatic reg_dec_t decode(input logic [ADDR_W-1:0] addr);
        reg_dec_t    d;
        logic [31:0] off;
        logic [31:0] rel;
        d   = '{kind: RK_NONE, err: 1'b1, idx: '0, ctx: '0};
        off = 32'(addr - BASE_A);
        rel = '0;
        if (off[1:0] != 2'b00) begin
            d.err = 1'b1;
        end else if (off < 32'h1000) begin
            d.kind = RK_PRIO;
            d.idx  = ID_W'(off[11:2]);
            d.err  = (32'(off[11:2]) >= 32'(NDEV));
        end else if (off < 32'h1080) begin
            d.kind = RK_PEND;
            d.idx  = ID_W'(off[6:2]);
            d.err  = (32'(off[6:2]) >= 32'(NWORDS));
        end else if (off >= 32'h1800 && off < 32'h1880) begin
            d.kind = RK_MODE;
            d.idx  = ID_W'(off[6:2]);
            d.err  = (32'(off[6:2]) >= 32'(NWORDS));
        end else if (off >= 32'h2000 && off < 32'h200000) begin
            rel    = off - 32'h2000;
            d.kind = RK_EN;
            d.idx  = ID_W'(rel[6:2]);
            d.ctx  = CTX_W'(rel >> 7);
            d.err  = (32'(rel[6:2]) >= 32'(NWORDS)) || ((rel >> 7) >= 32'(NCTX));
        end else if (off >= 32'h200000) begin
            rel   = off - 32'h200000;
            d.ctx = CTX_W'(rel >> 12);
            if (rel[11:0] == 12'h000)
                d.kind = RK_THR;
            else if (rel[11:0] == 12'h004)
                d.kind = RK_CLAIM;
            d.err = (d.kind == RK_NONE) || ((rel >> 12) >= 32'(NCTX));
        end
        return d;
    endfunction

    function automatic logic [31:0] get_word(input logic [NDEV-1:0] v,
                                             input logic [WORD_W-1:0] w);
        logic [NPAD-1:0] p;
        logic [31:0]     r;
        p = NPAD'(v);
        r = '0;
        for (int k = 0; k < NWORDS; k++)
            if (w == WORD_W'(k))
                r = p[k*32 +: 32];
        return r;
    endfunction

    function automatic logic [NDEV-1:0] set_word(input logic [NDEV-1:0] v,
                                                 input logic [WORD_W-1:0] w,
                                                 input logic [31:0] data);
        logic [NPAD-1:0] p;
        p = NPAD'(v);
        for (int k = 0; k < NWORDS; k++)
            if (w == WORD_W'(k))
                p[k*32 +: 32] = data;
        return p[NDEV-1:0];
    endfunction

    // Strict '>' gives lowest-ID-wins on ties and enforces prio > threshold.
    function automatic logic [ID_W-1:0] arbitrate(input logic [NDEV-1:0]   req,
                                                  input logic [PRIO_W-1:0] thr_c,
                                                  input logic [PRIO_W-1:0] p [NDEV]);
        logic [PRIO_W-1:0] bp;
        logic [ID_W-1:0]   bid;
        bp  = thr_c;
        bid = '0;
        for (int i = 1; i < NDEV; i++)
            if (req[i] && p[i] > bp) begin
                bp  = p[i];
                bid = ID_W'(i);
            end
        return bid;
    endfunction

    logic [PRIO_W-1:0] prio [NDEV];
    logic [NDEV-1:0]   en   [NCTX];
    logic [PRIO_W-1:0] thr  [NCTX];
    logic [ID_W-1:0]   best [NCTX];
    logic [NDEV-1:0]   pending, mode, in_service, edge_hold, int_prev;
    logic [NDEV-1:0]   pend_nxt, insv_nxt, hold_nxt, rise;

    wr_state_e         wr_state, wr_next;
    logic [ADDR_W-1:0] aw_addr;
    logic [7:0]        aw_id;
    logic [31:0]       w_data;
    logic [3:0]        w_strb;
    logic              aw_hs, w_hs, ar_hs, wr_apply;
    reg_dec_t          dec_w, dec_r;
    logic [31:0]       rd_val;
    logic [ID_W-1:0]   claim_id, cpl_id;
    logic              claim_fire, cpl_fire;

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;

    assign dec_w = decode(aw_addr);
    assign dec_r = decode(s_axi_araddr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            wr_state <= WR_IDLE;
        else
            wr_state <= wr_next;
    end

    always_comb begin
        wr_next       = wr_state;
        s_axi_awready = 1'b0;
        s_axi_wready  = 1'b0;
        s_axi_bvalid  = 1'b0;
        case (wr_state)
            WR_IDLE: begin
                s_axi_awready = 1'b1;
                s_axi_wready  = 1'b1;
                if (aw_hs && w_hs)
                    wr_next = WR_EXEC;
                else if (aw_hs)
                    wr_next = WR_ADDR;
                else if (w_hs)
                    wr_next = WR_DATA;
            end
            WR_ADDR: begin
                s_axi_wready = 1'b1;
                if (w_hs)
                    wr_next = WR_EXEC;
            end
            WR_DATA: begin
                s_axi_awready = 1'b1;
                if (aw_hs)
                    wr_next = WR_EXEC;
            end
            WR_EXEC: wr_next = WR_RESP;
            WR_RESP: begin
                s_axi_bvalid = 1'b1;
                if (s_axi_bready)
                    wr_next = WR_IDLE;
            end
            default: wr_next = WR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_addr     <= '0;
            aw_id       <= '0;
            w_data      <= '0;
            w_strb      <= '0;
            s_axi_bresp <= 2'b00;
        end else begin
            if (aw_hs) begin
                aw_addr <= s_axi_awaddr;
                aw_id   <= s_axi_awid;
            end
            if (w_hs) begin
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end
            if (wr_state == WR_EXEC)
                s_axi_bresp <= dec_w.err ? 2'b10 : 2'b00;
        end
    end

    assign s_axi_bid = aw_id;
    assign wr_apply  = (wr_state == WR_EXEC) && !dec_w.err && (w_strb == 4'hF);

    assign claim_id   = best[dec_r.ctx];
    assign claim_fire = ar_hs && !dec_r.err && (dec_r.kind == RK_CLAIM) && (claim_id != '0);
    assign cpl_id     = w_data[ID_W-1:0];
    assign cpl_fire   = wr_apply && (dec_w.kind == RK_CLAIM) &&
                        (w_data < 32'(NDEV)) && en[dec_w.ctx][cpl_id];

    // Gateways; the claim clear is applied last so it wins over a same-cycle set.
    always_comb begin
        pend_nxt = pending;
        insv_nxt = in_service;
        hold_nxt = edge_hold;
        rise     = int_vect & ~int_prev;
        if (cpl_fire)
            insv_nxt[cpl_id] = 1'b0;
        for (int i = 0; i < NDEV; i++) begin
            if (mode[i]) begin
                if (rise[i]) begin
                    if (in_service[i] && insv_nxt[i])
                        hold_nxt[i] = 1'b1;
                    else
                        pend_nxt[i] = 1'b1;
                end
                if (in_service[i] && !insv_nxt[i] && edge_hold[i]) begin
                    pend_nxt[i] = 1'b1;
                    hold_nxt[i] = 1'b0;
                end
            end else if (int_vect[i] && !in_service[i]) begin
                pend_nxt[i] = 1'b1;
            end
        end
        if (claim_fire) begin
            pend_nxt[claim_id] = 1'b0;
            insv_nxt[claim_id] = 1'b1;
        end
        pend_nxt = pend_nxt & SRC_MASK;
        insv_nxt = insv_nxt & SRC_MASK;
        hold_nxt = hold_nxt & SRC_MASK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NDEV; i++)
                prio[i] <= '0;
            for (int c = 0; c < NCTX; c++) begin
                en[c]   <= '0;
                thr[c]  <= '0;
                best[c] <= '0;
            end
            pending    <= '0;
            mode       <= '0;
            in_service <= '0;
            edge_hold  <= '0;
            int_prev   <= '0;
        end else begin
            int_prev   <= int_vect;
            pending    <= pend_nxt;
            in_service <= insv_nxt;
            edge_hold  <= hold_nxt;
            for (int c = 0; c < NCTX; c++)
                best[c] <= arbitrate(pending & en[c], thr[c], prio);
            if (wr_apply) begin
                case (dec_w.kind)
                    RK_PRIO: if (dec_w.idx != '0) prio[dec_w.idx] <= w_data[PRIO_W-1:0];
                    RK_MODE: mode <= set_word(mode, dec_w.idx[WORD_W-1:0], w_data);
                    RK_EN:   en[dec_w.ctx] <= set_word(en[dec_w.ctx], dec_w.idx[WORD_W-1:0],
                                                       w_data) & SRC_MASK;
                    RK_THR:  thr[dec_w.ctx] <= w_data[PRIO_W-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        irq = '0;
        for (int c = 0; c < NCTX; c++)
            irq[c] = (best[c] != '0);
    end

    always_comb begin
        rd_val = '0;
        if (!dec_r.err) begin
            case (dec_r.kind)
                RK_PRIO:  rd_val = 32'(prio[dec_r.idx]);
                RK_PEND:  rd_val = get_word(pending, dec_r.idx[WORD_W-1:0]);
                RK_MODE:  rd_val = get_word(mode, dec_r.idx[WORD_W-1:0]);
                RK_EN:    rd_val = get_word(en[dec_r.ctx], dec_r.idx[WORD_W-1:0]);
                RK_THR:   rd_val = 32'(thr[dec_r.ctx]);
                RK_CLAIM: rd_val = 32'(claim_id);
                default:  rd_val = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_axi_rvalid <= 1'b0;
            s_axi_rdata  <= '0;
            s_axi_rresp  <= 2'b00;
            s_axi_rid    <= '0;
        end else if (ar_hs) begin
            s_axi_rvalid <= 1'b1;
            s_axi_rdata  <= rd_val;
            s_axi_rresp  <= dec_r.err ? 2'b10 : 2'b00;
            s_axi_rid    <= s_axi_arid;
        end else if (s_axi_rvalid && s_axi_rready) begin
            s_axi_rvalid <= 1'b0;
        end
    end

    assign s_axi_arready = !s_axi_rvalid;
    assign s_axi_rlast   = 1'b1;

endmodule

// File: tb/tb_plic_gw.sv
// Directed bench for plic_gw: gateways, arbitration, claim/complete and
// AXI corner cases, checked against hand-computed values.
module tb_plic_gw;
    localparam int          NDEV   = 32;
    localparam int          NCTX   = 2;
    localparam int          PRIO_W = 3;
    localparam int          ADDR_W = 28;
    localparam logic [63:0] BASE   = 64'hc000000;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NDEV-1:0]   int_vect;
    logic [NCTX-1:0]   irq;
    logic [7:0]        s_axi_awid;
    logic [ADDR_W-1:0] s_axi_awaddr;
    logic              s_axi_awvalid, s_axi_awready;
    logic [31:0]       s_axi_wdata;
    logic [3:0]        s_axi_wstrb;
    logic              s_axi_wvalid, s_axi_wready;
    logic [7:0]        s_axi_bid;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid, s_axi_bready;
    logic [7:0]        s_axi_arid;
    logic [ADDR_W-1:0] s_axi_araddr;
    logic              s_axi_arvalid, s_axi_arready;
    logic [7:0]        s_axi_rid;
    logic [31:0]       s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rlast, s_axi_rvalid, s_axi_rready;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    plic_gw #(.NDEV(NDEV), .NCTX(NCTX), .PRIO_W(PRIO_W), .BASE(BASE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .int_vect(int_vect), .irq(irq),
        .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [ADDR_W-1:0] a_of(input logic [31:0] off);
        return ADDR_W'(BASE + 64'(off));
    endfunction

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_b();
        int n = 0;
        while (!s_axi_bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("b_handshake", 32'(s_axi_bvalid), 32'd1);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data, input logic [3:0] strb,
                      input logic [7:0] id, output logic [1:0] resp, output logic [7:0] bid_o);
        @(negedge clk);
        s_axi_awaddr  = a_of(off);
        s_axi_awid    = id;
        s_axi_awvalid = 1'b1;
        s_axi_wdata   = data;
        s_axi_wstrb   = strb;
        s_axi_wvalid  = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        wait_b();
        resp  = s_axi_bresp;
        bid_o = s_axi_bid;
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
    endtask

    task automatic w32(input logic [31:0] off, input logic [31:0] data);
        logic [1:0] resp;
        logic [7:0] b;
        wr(off, data, 4'hF, 8'h11, resp, b);
        check_eq("bresp_ok", 32'(resp), 32'd0);
    endtask

    task automatic rd(input logic [31:0] off, output logic [31:0] data, output logic [1:0] resp);
        int n = 0;
        @(negedge clk);
        s_axi_araddr  = a_of(off);
        s_axi_arid    = 8'h5A;
        s_axi_arvalid = 1'b1;
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        while (!s_axi_rvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq("r_handshake", 32'(s_axi_rvalid), 32'd1);
        data = s_axi_rdata;
        resp = s_axi_rresp;
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
    endtask

    task automatic r32(input logic [31:0] off, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        rd(off, d, r);
        check_eq(tag, d, exp);
        check_eq({tag, "_resp"}, 32'(r), 32'd0);
    endtask

    task automatic pulse(input int src);
        @(negedge clk);
        int_vect[src] = 1'b1;
        @(negedge clk);
        int_vect[src] = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [1:0]  r;
        logic [7:0]  b;
        int          n;
        int_vect = '0;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(1);
        check_eq("rst_irq", 32'(irq), 32'd0);
        check_eq("rst_awready", 32'(s_axi_awready), 32'd1);
        check_eq("rst_wready", 32'(s_axi_wready), 32'd1);
        check_eq("rst_arready", 32'(s_axi_arready), 32'd1);
        check_eq("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check_eq("rst_rvalid", 32'(s_axi_rvalid), 32'd0);

        // reset while AW is held and W has not arrived
        @(negedge clk);
        s_axi_awaddr = a_of(32'h1C); s_axi_awid = 8'h03; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        check_eq("aw_held_awready", 32'(s_axi_awready), 32'd0);
        check_eq("aw_held_wready", 32'(s_axi_wready), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("midrst_bvalid", 32'(s_axi_bvalid), 32'd0);
        check_eq("midrst_awready", 32'(s_axi_awready), 32'd1);
        check_eq("midrst_wready", 32'(s_axi_wready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        s_axi_wdata = 32'h5; s_axi_wstrb = 4'hF;
        r32(32'h1C, 32'h0, "prio7_after_rst");

        w32(32'h0, 32'h3);
        r32(32'h0, 32'h0, "prio0_hardwired");
        w32(32'h1C, 32'hF);
        r32(32'h1C, 32'h7, "prio_trunc");
        wr(32'h3000, 32'h1, 4'hF, 8'h3C, r, b);
        check_eq("wr_unmapped_bresp", 32'(r), 32'd2);
        check_eq("wr_unmapped_bid", 32'(b), 32'h3C);

        // level source 3
        w32(32'hC, 32'h2);
        w32(32'h2000, 32'h8);
        w32(32'h200000, 32'h1);
        int_vect[3] = 1'b1;
        idle(3);
        check_eq("irq_lvl", 32'(irq), 32'b01);
        r32(32'h200004, 32'd3, "claim_lvl");
        idle(2);
        check_eq("irq_lvl_insvc", 32'(irq), 32'b00);
        r32(32'h1000, 32'h0, "pend_lvl_insvc");
        w32(32'h200004, 32'd3);
        idle(3);
        check_eq("irq_lvl_repend", 32'(irq), 32'b01);
        r32(32'h1000, 32'h8, "pend_lvl_repend");
        r32(32'h200004, 32'd3, "claim_lvl2");
        int_vect[3] = 1'b0;
        w32(32'h200004, 32'd3);
        idle(3);
        check_eq("irq_lvl_low", 32'(irq), 32'b00);

        // edge source 5
        w32(32'h1800, 32'h20);
        w32(32'h14, 32'h2);
        w32(32'h2000, 32'h20);
        pulse(5);
        idle(3);
        check_eq("irq_edge", 32'(irq), 32'b01);
        r32(32'h200004, 32'd5, "claim_edge");
        pulse(5);
        idle(2);
        pulse(5);
        idle(3);
        check_eq("irq_edge_held", 32'(irq), 32'b00);
        r32(32'h1000, 32'h0, "pend_edge_held");
        w32(32'h200004, 32'd5);
        idle(3);
        r32(32'h1000, 32'h20, "pend_edge_repend");
        check_eq("irq_edge_repend", 32'(irq), 32'b01);
        r32(32'h200004, 32'd5, "claim_edge2");
        w32(32'h200004, 32'd5);
        idle(3);
        check_eq("irq_edge_single", 32'(irq), 32'b00);

        // equal-priority tie and priority change
        w32(32'h1800, 32'h0);
        w32(32'h2000, 32'h50);
        w32(32'h10, 32'h3);
        w32(32'h18, 32'h3);
        int_vect[4] = 1'b1;
        int_vect[6] = 1'b1;
        idle(3);
        r32(32'h200004, 32'd4, "claim_tie_low_id");
        w32(32'h200004, 32'd4);
        w32(32'h18, 32'h5);
        idle(3);
        r32(32'h200004, 32'd6, "claim_hi_prio");
        w32(32'h200004, 32'd6);
        idle(3);

        // threshold equal to priority, error decode
        w32(32'h18, 32'h3);
        w32(32'h200000, 32'h3);
        idle(3);
        check_eq("irq_thr_eq", 32'(irq), 32'b00);
        r32(32'h200004, 32'd0, "claim_none");
        rd(32'h3000, d, r);
        check_eq("rd_unmapped_data", d, 32'h0);
        check_eq("rd_unmapped_resp", 32'(r), 32'd2);
        rd(32'h80, d, r);
        check_eq("rd_src_oob_resp", 32'(r), 32'd2);
        rd(32'h202000, d, r);
        check_eq("rd_ctx_oob_resp", 32'(r), 32'd2);

        // second context and complete from a non-enabled context
        w32(32'h2000, 32'h10);
        w32(32'h2080, 32'h40);
        idle(3);
        check_eq("irq_ctx1", 32'(irq), 32'b10);
        r32(32'h201004, 32'd6, "claim_ctx1");
        idle(2);
        check_eq("irq_ctx1_insvc", 32'(irq), 32'b00);
        w32(32'h200004, 32'd6);
        idle(3);
        check_eq("cpl_wrong_ctx", 32'(irq), 32'b00);
        w32(32'h201004, 32'd6);
        idle(3);
        check_eq("cpl_ctx1", 32'(irq), 32'b10);

        // W before AW with a partial strobe
        @(negedge clk);
        s_axi_wdata = 32'h7; s_axi_wstrb = 4'b0111; s_axi_wvalid = 1'b1;
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        check_eq("w_held_wready", 32'(s_axi_wready), 32'd0);
        check_eq("w_held_awready", 32'(s_axi_awready), 32'd1);
        s_axi_awaddr = a_of(32'h8); s_axi_awid = 8'hA5; s_axi_awvalid = 1'b1;
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        wait_b();
        check_eq("partial_bresp", 32'(s_axi_bresp), 32'd0);
        check_eq("partial_bid", 32'(s_axi_bid), 32'hA5);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        r32(32'h8, 32'h0, "prio2_partial_strb");

        w32(32'h2080, 32'hFFFF_FFFF);
        r32(32'h2080, 32'hFFFF_FFFE, "en_src0_hw");

        n = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/plic_gw.md
Name: plic_gw

Overview:
- Second-generation platform-level interrupt controller with a single-beat AXI slave register interface.
- Adds per-source level/edge gateways with claim/complete in-service locking.
- Parametrised source count, context count and priority width; one registered irq line per context.
- Sits between device interrupt lines and the core CSR interrupt-pending logic.

Parameters:
NDEV, 32, interrupt sources including reserved source 0 (2..1024)
NCTX, 2, interrupt targets/contexts (1..15872)
PRIO_W, 3, implemented priority bits; upper register bits read 0
BASE, 64'hc000000, base address of the register window
ADDR_W, 28, AXI address width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
int_vect  in  NDEV  raw device interrupt lines; bit 0 ignored
irq  out  NCTX  per-context interrupt request
s_axi_awid  in  8  write id
s_axi_awaddr  in  ADDR_W  write address
s_axi_awvalid  in  1  AW valid
s_axi_awready  out  1  AW ready
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes; a write takes effect only if all 4 set
s_axi_wvalid  in  1  W valid
s_axi_wready  out  1  W ready
s_axi_bid  out  8  echoed awid
s_axi_bresp  out  2  0 OKAY, 2 SLVERR
s_axi_bvalid  out  1  B valid
s_axi_bready  in  1  B ready
s_axi_arid  in  8  read id
s_axi_araddr  in  ADDR_W  read address
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  8  echoed arid
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  0 OKAY, 2 SLVERR
s_axi_rlast  out  1  constant 1
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready

Behaviour:
- Reset (async on rst_n low): irq=0, arready/awready/wready=1, rvalid/bvalid=0, all priority/pending/enable/threshold/mode/in-service cleared.
- Map (offset = addr-BASE): priority 0x0+4i; pending 0x1000+4w (read-only); mode 0x1800+4w (1=edge); enable 0x2000+0x80c+4w; threshold 0x200000+0x1000c; claim/complete 0x200004+0x1000c.
- Unmapped offset, source>=NDEV or context>=NCTX -> SLVERR; reads return 0; writes have no effect.
- Source 0: priority, pending and enable hardwired to 0.
- Gateway, level source: pending set while line high and source not in-service.
- Gateway, edge source: 0->1 transition (registered previous value) sets pending; edges seen while in-service are latched in one edge-hold bit and re-pend on completion.
- Arbitration per context: best = lowest ID among pending & enabled sources with maximal priority; eligible only if priority > threshold. Result registered -> irq and claim value valid 1 cycle after state change.
- irq[c] = (best[c] != 0).
- Claim read: returns best[c]; clears pending, sets in-service for that ID in the same cycle the AR handshake completes; returns 0 if none.
- Complete write (data = ID): clears in-service only if ID is enabled for that context; else ignored with OKAY.
- Simultaneous claim from two contexts in one cycle is impossible: one AR port, single outstanding read.
- Write: AW and W accepted independently in any order (each ready drops after its handshake); register update and bvalid in the cycle after both are held. Ready signals restore on the B handshake.
- Read: rvalid the cycle after the AR handshake; arready restores on the R handshake.
- Same-cycle gateway set and claim clear for one ID: claim wins.
- Priority writes are truncated to PRIO_W bits.

Test Plan:
- Reset mid-write (AW accepted, W pending, rst_n low) -> bvalid=0, awready=wready=1, written register unchanged.
- Level src 3, prio 2, enabled ctx0, threshold 1 -> irq[0]=1; claim returns 3; irq[0]=0 while line still high; complete 3 -> irq[0]=1 again.
- Edge src 5, two pulses during in-service -> one re-pend after complete; pending word0 bit5=1.
- Srcs 4 and 6, both prio 3 -> claim returns 4; set src 6 prio 5 -> claim returns 6.
- Threshold 3 with src prio 3 -> irq=0; read of offset 0x3000 with NDEV=32 -> rresp=2, rdata=0.
- W before AW, wstrb=4'b0111 -> bresp=0, register unchanged; bid equals awid.
